// File: rtl/vram_writer.sv
// Copies one frame of Z88 screen bytes from system memory into the 4-bit VRAM, two pixels per byte.
// Optional build macro VRAM_WRITER_INVERT_EN adds an 'invert' input for reverse video.
module vram_writer #(
  parameter int MEM_AW         = 22,
  parameter int LINES          = 64,
  parameter int BYTES_PER_LINE = 80,
  parameter int LINE_STRIDE    = 80
) (
  input  logic              clk25,
  input  logic              reset_n,
  input  logic              lcdon,
  input  logic              frame_start,
  input  logic [MEM_AW-1:0] scr_base,
`ifdef VRAM_WRITER_INVERT_EN
  input  logic              invert,
`endif
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_a,
  input  logic              mem_ack,
  input  logic [7:0]        mem_di,
  output logic              vram_we,
  output logic [13:0]       vram_a,
  output logic [3:0]        vram_do,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {IDLE, REQ, WR_LO, WR_HI, DONE} state_e;

  localparam logic [5:0] LAST_LINE = 6'(LINES - 1);
  localparam logic [6:0] LAST_BYTE = 7'(BYTES_PER_LINE - 1);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [5:0]        line_cnt_q, line_cnt_d;
  logic [6:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_a_q, mem_a_d;
  logic              vram_we_q, vram_we_d;
  logic [13:0]       vram_a_q, vram_a_d;
  logic [3:0]        vram_do_q, vram_do_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              start_ok;
  logic              frame_last;
  logic [3:0]        inv_mask;

  assign start_ok   = (state_q == IDLE) && (state_d == REQ);
  assign frame_last = (line_cnt_q == LAST_LINE) && (byte_cnt_q == LAST_BYTE);

`ifdef VRAM_WRITER_INVERT_EN
  logic inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (start_ok) inv_d = invert;
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end

  assign inv_mask = {4{inv_q}};
`else
  assign inv_mask = 4'h0;
`endif

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      line_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      data_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_a_q      <= '0;
      vram_we_q    <= 1'b0;
      vram_a_q     <= '0;
      vram_do_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      line_cnt_q   <= line_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      mem_req_q    <= mem_req_d;
      mem_a_q      <= mem_a_d;
      vram_we_q    <= vram_we_d;
      vram_a_q     <= vram_a_d;
      vram_do_q    <= vram_do_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Dropping lcdon wins over every transition, including a pending ack.
  always_comb begin
    state_d = state_q;
    if (!lcdon) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (frame_start) state_d = REQ;
        REQ:     if (mem_ack) state_d = WR_LO;
        WR_LO:   state_d = WR_HI;
        WR_HI:   state_d = frame_last ? DONE : REQ;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    base_d     = base_q;
    line_cnt_d = line_cnt_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    if (start_ok) begin
      base_d     = scr_base;
      line_cnt_d = '0;
      byte_cnt_d = '0;
    end
    if ((state_q == REQ) && (state_d == WR_LO)) data_d = mem_di;
    if (state_q == WR_HI) begin
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d = '0;
        line_cnt_d = line_cnt_q + 6'd1;
      end else begin
        byte_cnt_d = byte_cnt_q + 7'd1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    mem_req_d    = (state_d == REQ);
    mem_a_d      = mem_a_q;
    vram_we_d    = (state_d == WR_LO) || (state_d == WR_HI);
    vram_a_d     = vram_a_q;
    vram_do_d    = vram_do_q;
    busy_d       = (state_d == REQ) || (state_d == WR_LO) || (state_d == WR_HI);
    frame_done_d = (state_d == DONE);
    if (state_d == REQ) begin
      mem_a_d = base_d + MEM_AW'(line_cnt_d) * MEM_AW'(LINE_STRIDE) + MEM_AW'(byte_cnt_d);
    end
    if (state_d == WR_LO) begin
      vram_a_d  = {line_cnt_q, byte_cnt_q, 1'b0};
      vram_do_d = mem_di[3:0] ^ inv_mask;
    end else if (state_d == WR_HI) begin
      vram_a_d  = {line_cnt_q, byte_cnt_q, 1'b1};
      vram_do_d = data_q[7:4] ^ inv_mask;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_a      = mem_a_q;
  assign vram_we    = vram_we_q;
  assign vram_a     = vram_a_q;
  assign vram_do    = vram_do_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: a memory responder feeds bytes and queues the VRAM writes they
// should cause; a monitor pops and compares every write. Vector table covers first-byte behaviour.
module tb_vram_writer;

  localparam int AW = 22;
`ifdef VRAM_WRITER_INVERT_EN
  localparam bit INV_BUILD = 1'b1;
`else
  localparam bit INV_BUILD = 1'b0;
`endif

  logic          clk25;
  logic          reset_n;
  logic          lcdon;
  logic          frame_start;
  logic [AW-1:0] scr_base;
`ifdef VRAM_WRITER_INVERT_EN
  logic          invert_r;
`endif
  logic          mem_req;
  logic [AW-1:0] mem_a;
  logic          mem_ack;
  logic [7:0]    mem_di;
  logic          vram_we;
  logic [13:0]   vram_a;
  logic [3:0]    vram_do;
  logic          busy;
  logic          frame_done;

  vram_writer dut (
    .clk25       (clk25),
    .reset_n     (reset_n),
    .lcdon       (lcdon),
    .frame_start (frame_start),
    .scr_base    (scr_base),
`ifdef VRAM_WRITER_INVERT_EN
    .invert      (invert_r),
`endif
    .mem_req     (mem_req),
    .mem_a       (mem_a),
    .mem_ack     (mem_ack),
    .mem_di      (mem_di),
    .vram_we     (vram_we),
    .vram_a      (vram_a),
    .vram_do     (vram_do),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clk25 = 1'b0;
  initial forever #20 clk25 = ~clk25;

  typedef struct {
    logic [AW-1:0] base;
    logic [7:0]    dat;
    logic          inv;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [3:0]    lo;
    logic [3:0]    hi;
  } vec_t;

  vec_t          vecs[4];
  int            total = 0;
  int            bad = 0;
  logic [17:0]   exp_q[$];
  logic [17:0]   wlog[$];
  logic [AW-1:0] alog[$];
  logic [AW-1:0] base_m;
  logic          inv_m;
  logic [7:0]    fixed_byte;
  bit            data_mode;
  bit            resp_en;
  int            ack_delay;
  int            wait_cnt;
  int            k;
  int            writes;
  int            done_count = 0;
  logic [13:0]   last_a;
  logic          prev_busy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic inv, input logic [7:0] dat,
                               input bit mode, input int dly);
    @(negedge clk25);
    base_m     = base;
    inv_m      = inv;
    k          = 0;
    wait_cnt   = 0;
    writes     = 0;
    fixed_byte = dat;
    data_mode  = mode;
    ack_delay  = dly;
    exp_q.delete();
    alog.delete();
    wlog.delete();
    scr_base    = base;
`ifdef VRAM_WRITER_INVERT_EN
    invert_r    = inv;
`endif
    frame_start = 1'b1;
    resp_en     = 1'b1;
    @(negedge clk25);
    frame_start = 1'b0;
    checkOutput("req_rise", 32'(mem_req), 32'd1);
    checkOutput("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic abortFrame();
    @(negedge clk25);
    lcdon   = 1'b0;
    resp_en = 1'b0;
    repeat (3) @(negedge clk25);
    exp_q.delete();
    lcdon = 1'b1;
  endtask

  // Memory responder: acks after ack_delay cycles and queues the two writes each byte must produce.
  initial begin
    logic [7:0]    d;
    logic [AW-1:0] ea;
    logic [13:0]   va;
    logic [3:0]    im;
    forever begin
      @(negedge clk25);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (resp_en && mem_req) begin
        ea = base_m + k[AW-1:0];
        if (ack_delay > 0) begin
          checkOutput("mem_a_hold", 32'(mem_a), 32'(ea));
          checkOutput("we_during_wait", 32'(vram_we), 32'd0);
        end
        if (wait_cnt >= ack_delay) begin
          checkOutput("mem_a", 32'(mem_a), 32'(ea));
          d  = data_mode ? fixed_byte : ea[7:0];
          im = (inv_m && INV_BUILD) ? 4'hF : 4'h0;
          va = 14'(((k / 80) << 8) + (k % 80) * 2);
          exp_q.push_back({va, d[3:0] ^ im});
          exp_q.push_back({va | 14'd1, d[7:4] ^ im});
          alog.push_back(mem_a);
          mem_di   = d;
          mem_ack  = 1'b1;
          k++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Write monitor / scoreboard.
  initial begin
    logic [17:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk25);
      if (vram_we) begin
        writes++;
        last_a = vram_a;
        wlog.push_back({vram_a, vram_do});
        if (exp_q.size() == 0) begin
          checkOutput("spurious_we", 32'(vram_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write", 32'({vram_a, vram_do}), 32'(e));
        end
      end
      if (frame_done) begin
        done_count++;
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("busy_before_done", 32'(prev_busy), 32'd1);
      end
      prev_busy = busy;
    end
  end

  initial begin
    #(40 * 90000);
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int w0;
    reset_n     = 1'b0;
    lcdon       = 1'b1;
    frame_start = 1'b0;
    scr_base    = '0;
`ifdef VRAM_WRITER_INVERT_EN
    invert_r    = 1'b0;
`endif
    mem_ack     = 1'b0;
    mem_di      = '0;
    resp_en     = 1'b0;
    base_m      = '0;
    inv_m       = 1'b0;
    fixed_byte  = '0;
    data_mode   = 1'b0;
    ack_delay   = 0;
    wait_cnt    = 0;
    k           = 0;
    writes      = 0;
    last_a      = '0;

    vecs[0] = '{base: 22'h001000, dat: 8'hA5, inv: 1'b0, a0: 22'h001000, a1: 22'h001001, lo: 4'h5, hi: 4'hA};
    vecs[1] = '{base: 22'h000000, dat: 8'h0F, inv: 1'b0, a0: 22'h000000, a1: 22'h000001, lo: 4'hF, hi: 4'h0};
    vecs[2] = '{base: 22'h3FFFFF, dat: 8'h3C, inv: 1'b0, a0: 22'h3FFFFF, a1: 22'h000000, lo: 4'hC, hi: 4'h3};
`ifdef VRAM_WRITER_INVERT_EN
    vecs[3] = '{base: 22'h2ABCDE, dat: 8'h0F, inv: 1'b1, a0: 22'h2ABCDE, a1: 22'h2ABCDF, lo: 4'h0, hi: 4'hF};
`else
    vecs[3] = '{base: 22'h2ABCDE, dat: 8'h0F, inv: 1'b1, a0: 22'h2ABCDE, a1: 22'h2ABCDF, lo: 4'hF, hi: 4'h0};
`endif

    repeat (3) @(negedge clk25);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_a", 32'(mem_a), 32'd0);
    checkOutput("rst_vram_we", 32'(vram_we), 32'd0);
    checkOutput("rst_vram_a", 32'(vram_a), 32'd0);
    checkOutput("rst_vram_do", 32'(vram_do), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk25);

    // First-byte vectors, including address wrap and reverse video.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].base, vecs[i].inv, vecs[i].dat, 1'b1, 0);
      for (int c = 0; c < 50 && (alog.size() < 2 || wlog.size() < 2); c++) @(negedge clk25);
      if (alog.size() < 2 || wlog.size() < 2) begin
        checkOutput("vec_timeout", 32'(wlog.size()), 32'd2);
      end else begin
        checkOutput("vec_mem_a0", 32'(alog[0]), 32'(vecs[i].a0));
        checkOutput("vec_mem_a1", 32'(alog[1]), 32'(vecs[i].a1));
        checkOutput("vec_write_lo", 32'(wlog[0]), 32'({14'h0000, vecs[i].lo}));
        checkOutput("vec_write_hi", 32'(wlog[1]), 32'({14'h0001, vecs[i].hi}));
      end
      abortFrame();
    end

    // Full frame, data = low address byte.
    d0 = done_count;
    applyStimulus(22'h012345, 1'b0, 8'h00, 1'b0, 0);
    for (int c = 0; c < 20000 && done_count == d0; c++) @(negedge clk25);
    repeat (2) @(negedge clk25);
    checkOutput("full_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("full_writes", 32'(writes), 32'd10240);
    checkOutput("full_last_a", 32'(last_a), 32'h3F9F);
    checkOutput("full_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("full_idle_busy", 32'(busy), 32'd0);
    checkOutput("full_done_pulse", 32'(frame_done), 32'd0);

    // Delayed ack, then abort during a wait and send a stray ack.
    applyStimulus(22'h001000, 1'b0, 8'h00, 1'b0, 7);
    for (int c = 0; c < 1000 && writes < 10; c++) @(negedge clk25);
    checkOutput("delay_writes", 32'(writes >= 10), 32'd1);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk25);
      #1;
      if (mem_req) break;
    end
    resp_en = 1'b0;
    lcdon   = 1'b0;
    w0      = writes;
    @(negedge clk25);
    mem_di  = 8'hFF;
    mem_ack = 1'b1;
    repeat (4) @(negedge clk25);
    checkOutput("stray_ack_req", 32'(mem_req), 32'd0);
    checkOutput("stray_ack_busy", 32'(busy), 32'd0);
    checkOutput("stray_ack_writes", 32'(writes - w0), 32'd0);
    exp_q.delete();
    lcdon = 1'b1;

    // lcdon drop after 100 writes, then restart from the top.
    d0 = done_count;
    applyStimulus(22'h002000, 1'b0, 8'h00, 1'b0, 0);
    for (int c = 0; c < 1000 && writes < 100; c++) begin
      @(posedge clk25);
      #1;
    end
    lcdon   = 1'b0;
    resp_en = 1'b0;
    @(posedge clk25);
    #1;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_vram_we", 32'(vram_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    w0 = writes;
    repeat (5) @(negedge clk25);
    checkOutput("abort_no_writes", 32'(writes - w0), 32'd0);
    checkOutput("abort_no_done", 32'(done_count - d0), 32'd0);
    exp_q.delete();
    lcdon = 1'b1;
    applyStimulus(22'h002000, 1'b0, 8'h00, 1'b0, 0);
    for (int c = 0; c < 50 && wlog.size() < 1; c++) @(negedge clk25);
    if (wlog.size() < 1) checkOutput("restart_timeout", 32'(wlog.size()), 32'd1);
    else checkOutput("restart_vram_a", 32'(wlog[0][17:4]), 32'h0000);
    abortFrame();

    // Reset mid-frame.
    applyStimulus(22'h000400, 1'b0, 8'h00, 1'b0, 0);
    for (int c = 0; c < 500 && writes < 20; c++) begin
      @(posedge clk25);
      #1;
    end
    reset_n = 1'b0;
    resp_en = 1'b0;
    @(posedge clk25);
    #1;
    checkOutput("mrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mrst_mem_a", 32'(mem_a), 32'd0);
    checkOutput("mrst_vram_we", 32'(vram_we), 32'd0);
    checkOutput("mrst_vram_a", 32'(vram_a), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk25);
    reset_n = 1'b1;
    exp_q.delete();
    w0 = writes;
    repeat (10) @(negedge clk25);
    checkOutput("mrst_no_writes", 32'(writes - w0), 32'd0);

    // Full frame with ignored frame_start pulses; base wraps past the top of memory.
    d0 = done_count;
    applyStimulus(22'h3FFF00, 1'b0, 8'h00, 1'b0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 20000 && writes < (p == 0 ? 500 : 5000); c++) begin
        @(posedge clk25);
        #1;
      end
      scr_base    = 22'h111111;
      frame_start = 1'b1;
      @(posedge clk25);
      #1;
      frame_start = 1'b0;
    end
    for (int c = 0; c < 20000 && done_count == d0; c++) @(negedge clk25);
    repeat (2) @(negedge clk25);
    checkOutput("pulse_done_count", 32'(done_count - d0), 32'd1);
    checkOutput("pulse_writes", 32'(writes), 32'd10240);
    checkOutput("pulse_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
